ex_stage: RTL

//  MIPS pipeline execute stage plus EX/MEM pipeline register; sits between ID/EX and MEMORY.

---
 rtl/ex_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// MIPS execute stage with EX/MEM register and iterative MULTU (HI/LO).
// In: id_* operands/control, flush. Out: ex_* registered bundle, stall_out.
module ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     id_pc4,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_dst,
  input  logic                  id_alu_src,
  input  logic [1:0]            id_alu_op,
  input  logic [5:0]            id_funct,
  input  logic                  id_mem_write,
  input  logic                  id_mem_read,
  input  logic                  id_branch,
  input  logic                  id_reg_write,
  input  logic                  id_mem_to_reg,
  output logic                  stall_out,
  output logic [DATA_W-1:0]     ex_branch_target,
  output logic                  ex_zero,
  output logic [DATA_W-1:0]     ex_alu_result,
  output logic [DATA_W-1:0]     ex_write_data,
  output logic [REG_ADDR_W-1:0] ex_dest_reg,
  output logic                  ex_mem_write,
  output logic                  ex_mem_read,
  output logic                  ex_branch,
  output logic                  ex_reg_write,
  output logic                  ex_mem_to_reg
);

  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULTU = 6'h19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mState_t;

  mState_t state, nextState;

  logic [DATA_W-1:0]   bOp;
  logic [DATA_W-1:0]   aluRes;
  logic                isMultu;
  logic                bubble;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   mcand;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] prodNext;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   hi;
  logic [DATA_W-1:0]   lo;
  logic                lastStep;

  assign isMultu  = (id_alu_op == 2'b10) && (id_funct == F_MULTU);
  assign lastStep = (cnt == CNT_W'(DATA_W - 1));

  // {acc, multiplier}: add multiplicand into acc on LSB, shift right.
  assign sum      = {1'b0, prod[2*DATA_W-1:DATA_W]}
                  + (prod[0] ? {1'b0, mcand} : '0);
  assign prodNext = {sum, prod[DATA_W-1:1]};

  always_comb begin
    bOp    = id_alu_src ? id_imm : id_rt_data;
    aluRes = '0;
    unique case (id_alu_op)
      2'b01: aluRes = id_rs_data - bOp;
      2'b10: begin
        case (id_funct)
          F_ADD:   aluRes = id_rs_data + bOp;
          F_SUB:   aluRes = id_rs_data - bOp;
          F_AND:   aluRes = id_rs_data & bOp;
          F_OR:    aluRes = id_rs_data | bOp;
          F_SLT:   aluRes = {{(DATA_W-1){1'b0}},
                    $signed(id_rs_data) < $signed(bOp)};
          F_MFHI:  aluRes = hi;
          F_MFLO:  aluRes = lo;
          default: aluRes = '0;
        endcase
      end
      default: aluRes = id_rs_data + bOp;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (isMultu && !flush) nextState = BUSY;
      BUSY: begin
        if (flush)         nextState = IDLE;
        else if (lastStep) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    stall_out = 1'b0;
    unique case (state)
      IDLE:    stall_out = isMultu && !flush;
      BUSY:    stall_out = 1'b1;
      default: stall_out = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      mcand <= '0;
      prod  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (state == IDLE) begin
      if (isMultu && !flush) begin
        cnt   <= '0;
        mcand <= id_rs_data;
        prod  <= {{DATA_W{1'b0}}, id_rt_data};
      end
    end else if (state == BUSY && !flush) begin
      cnt  <= cnt + 1'b1;
      prod <= prodNext;
      if (lastStep) {hi, lo} <= prodNext;
    end
  end

  assign bubble = flush || isMultu || (state == BUSY);

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_branch_target <= '0;
      ex_zero          <= 1'b0;
      ex_alu_result    <= '0;
      ex_write_data    <= '0;
      ex_dest_reg      <= '0;
      ex_mem_write     <= 1'b0;
      ex_mem_read      <= 1'b0;
      ex_branch        <= 1'b0;
      ex_reg_write     <= 1'b0;
      ex_mem_to_reg    <= 1'b0;
    end else begin
      ex_branch_target <= id_pc4 + (id_imm << 2);
      ex_zero          <= (aluRes == '0);
      ex_alu_result    <= aluRes;
      ex_write_data    <= id_rt_data;
      ex_dest_reg      <= id_reg_dst ? id_rd : id_rt;
      ex_mem_write     <= id_mem_write;
      ex_mem_read      <= id_mem_read;
      ex_branch        <= id_branch;
      ex_reg_write     <= id_reg_write;
      ex_mem_to_reg    <= id_mem_to_reg;
    end
  end

endmodule
